// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine and its food generator.
// Segment k of the packed location bus sits at [FLAT_W-1-SEG_W*k -: SEG_W].
package snake_pkg;

    typedef enum logic [2:0] {
        QI = 3'd0,
        QC = 3'd1,
        QF = 3'd2,
        QL = 3'd3,
        QW = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam int GRID_DIM = 16;
    localparam int SEG_W    = 8;
    localparam int NUM_SEGS = 16;
    localparam int FLAT_W   = SEG_W * NUM_SEGS;

    localparam logic [SEG_W-1:0] INIT_FOOD = 8'h8B;
    // Taps for x^8+x^6+x^5+x^4+1 on a shift-left Fibonacci register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    function automatic logic [SEG_W-1:0] init_seg(input int k, input int init_len);
        if (k < init_len)
            return 8'h80 + 8'(init_len - k);
        return 8'h00;
    endfunction

endpackage

// File: rtl/snake_food_gen.sv
// Free-running food LFSR plus occupancy check against the live snake body.
// done is asserted combinationally while req is held and the candidate cell is free.
module snake_food_gen
    import snake_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req,
    input  logic [FLAT_W-1:0] locations_flat,
    input  logic [3:0]        length,
    output logic [SEG_W-1:0]  food_idx,
    output logic              done
);

    logic [7:0] lfsr;
    logic       occupied;

    // A nonzero seed never reaches zero, so cell 00 is never offered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        occupied = 1'b0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            if ((5'(k) < {1'b0, length}) &&
                (locations_flat[FLAT_W-1-SEG_W*k -: SEG_W] == lfsr))
                occupied = 1'b1;
        end
    end

    assign food_idx = lfsr;
    assign done     = req && !occupied;

endmodule

// File: rtl/snake_game_engine.sv
// Snake game-state engine: body positions, direction, food, length and win/lose
// state, advancing one cell per Tick; outputs feed the display renderer.
module snake_game_engine
    import snake_pkg::*;
#(
    parameter int         MAX_LEN   = 15,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Tick,
    input  logic              Start,
    input  logic              BtnU,
    input  logic              BtnD,
    input  logic              BtnL,
    input  logic              BtnR,
    output logic [SEG_W-1:0]  Food,
    output logic [3:0]        Length,
    output logic [FLAT_W-1:0] Locations_Flat,
    output logic              Qi,
    output logic              Qc,
    output logic              Ql,
    output logic              Qw
);

    state_t           state, state_next;
    dir_t             dir_last, dir_latched, dir_req, move_ref;
    logic             req_valid;
    logic [SEG_W-1:0] segs [NUM_SEGS];
    logic [SEG_W-1:0] head, head_next;
    logic [3:0]       limit;
    logic             wall_hit, eat, self_hit, do_move;
    logic             food_done;
    logic [SEG_W-1:0] food_idx;

    always_comb begin
        req_valid = 1'b1;
        dir_req   = dir_latched;
        if (BtnU)      dir_req = UP;
        else if (BtnD) dir_req = DOWN;
        else if (BtnL) dir_req = LEFT;
        else if (BtnR) dir_req = RIGHT;
        else           req_valid = 1'b0;
    end

    // On a Tick cycle the move in progress uses dir_latched, so reversals are judged against it.
    assign move_ref = Tick ? dir_latched : dir_last;
    assign head     = segs[0];

    always_comb begin
        wall_hit  = 1'b0;
        head_next = head;
        case (dir_latched)
            UP: begin
                wall_hit  = (head[7:4] == 4'd0);
                head_next = head - 8'(GRID_DIM);
            end
            DOWN: begin
                wall_hit  = (head[7:4] == 4'(GRID_DIM - 1));
                head_next = head + 8'(GRID_DIM);
            end
            LEFT: begin
                wall_hit  = (head[3:0] == 4'd0);
                head_next = head - 8'd1;
            end
            default: begin
                wall_hit  = (head[3:0] == 4'(GRID_DIM - 1));
                head_next = head + 8'd1;
            end
        endcase
    end

    // The tail cell only counts as an obstacle when the snake grows this move.
    always_comb begin
        eat      = (head_next == Food);
        limit    = eat ? Length : Length - 4'd1;
        self_hit = 1'b0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            if ((5'(k) < {1'b0, limit}) && (segs[k] == head_next))
                self_hit = 1'b1;
        end
    end

    assign do_move = (state == QC) && Tick && !Start && !wall_hit && !self_hit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= QI;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            QI: if (Start) state_next = QC;
            QC: begin
                if (Start)
                    state_next = QI;
                else if (Tick) begin
                    if (wall_hit || self_hit)
                        state_next = QL;
                    else if (eat)
                        state_next = (({1'b0, Length} + 5'd1) == 5'(MAX_LEN)) ? QW : QF;
                end
            end
            QF: begin
                if (Start)
                    state_next = QI;
                else if (food_done)
                    state_next = QC;
            end
            QL, QW: if (Start) state_next = QI;
            default: state_next = QI;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Length      <= 4'(INIT_LEN);
            Food        <= INIT_FOOD;
            dir_last    <= RIGHT;
            dir_latched <= RIGHT;
            for (int k = 0; k < NUM_SEGS; k++)
                segs[k] <= init_seg(k, INIT_LEN);
        end else if (Start) begin
            Length      <= 4'(INIT_LEN);
            Food        <= INIT_FOOD;
            dir_last    <= RIGHT;
            dir_latched <= RIGHT;
            for (int k = 0; k < NUM_SEGS; k++)
                segs[k] <= init_seg(k, INIT_LEN);
        end else begin
            if ((state == QC) && req_valid && (dir_req != opposite(move_ref)))
                dir_latched <= dir_req;
            if (do_move) begin
                dir_last <= dir_latched;
                segs[0]  <= head_next;
                for (int k = 1; k < NUM_SEGS; k++)
                    segs[k] <= segs[k-1];
                if (eat)
                    Length <= Length + 4'd1;
            end
            if ((state == QF) && food_done)
                Food <= food_idx;
        end
    end

    for (genvar k = 0; k < NUM_SEGS; k++) begin : g_pack
        assign Locations_Flat[FLAT_W-1-SEG_W*k -: SEG_W] = segs[k];
    end

    snake_food_gen #(
        .LFSR_SEED(LFSR_SEED)
    ) u_food_gen (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .req           (state == QF),
        .locations_flat(Locations_Flat),
        .length        (Length),
        .food_idx      (food_idx),
        .done          (food_done)
    );

    assign Qi = (state == QI);
    assign Qc = (state == QC);
    assign Ql = (state == QL);
    assign Qw = (state == QW);

endmodule
